// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder; the arithmetic core of the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first,
// with a valid/ready start handshake and a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH %0d outside legal range", WIDTH);
  end

  sa_state_t        r_state;
  sa_state_t        w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ps;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_carry_out;
  logic             r_overflow;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_cout;

  assign w_accept = start_valid && start_ready;
  assign w_last   = (r_state == BUSY) && (r_cnt == CNT_W'(WIDTH - 1));

  fa_bit u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = BUSY;
      BUSY:    if (w_last)   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (r_state == IDLE) && rst_n;
    done        = (r_state == DONE);
    busy        = (r_state != IDLE);
  end

  // On the last bit r_c still holds the carry into the MSB, so overflow is
  // formed directly from it and the carry out of the cell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa        <= '0;
      r_sb        <= '0;
      r_ps        <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= sub ? ~b : b;
      r_c   <= sub ? 1'b1 : carry_in;
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      r_ps  <= {w_s, r_ps[WIDTH-1:1]};
      r_c   <= w_cout;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum       <= {w_s, r_ps[WIDTH-1:1]};
        r_carry_out <= w_cout;
        r_overflow  <= r_c ^ w_cout;
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
